mod_sampler: RTL and testbench



---
 rtl/mod_sampler_pkg.sv | 25 ++
 rtl/mod_sampler_if.sv | 35 +++
 rtl/mod_sampler_tick_divider.sv | 46 ++++
 rtl/mod_sampler.sv | 116 +++++++++++
 tb/tb_mod_sampler.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mod_sampler_pkg.sv
// -----------------------------------------------------------------------------
// mod_pkg: shared definitions for the modulation sampler.
//   - default widths / latency for the sampler and its interface
//   - FSM state encoding
//   - helper to size the BRAM latency counter
// -----------------------------------------------------------------------------
package mod_pkg;

   localparam int DEF_ADDR_WIDTH   = 15;
   localparam int DEF_BRAM_LATENCY = 2;
   localparam int DEF_DIV_WIDTH    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_e;

   function automatic int lat_cnt_width(input int latency);
      return $clog2(latency + 1);
   endfunction

   localparam int LAT_CNT_W = lat_cnt_width(DEF_BRAM_LATENCY);

endpackage

// File: rtl/mod_sampler_if.sv
// -----------------------------------------------------------------------------
// mod_sampler_if: bundles the sampler's timing, BRAM and multiplier-side
// signals.
//   slave  : seen from the sampler (TICK/SYNC/config/READY/MOD_DATA in,
//            MOD_ADDR/MOD/UPDATE/MOD_IDX/OVERRUN out)
//   master : seen from the surrounding system (directions reversed)
// -----------------------------------------------------------------------------
interface mod_sampler_if
   import mod_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DIV_WIDTH  = DEF_DIV_WIDTH
);
   logic                  TICK;
   logic                  SYNC;
   logic [DIV_WIDTH-1:0]  FREQ_DIV;
   logic [ADDR_WIDTH-1:0] MOD_CYCLE;
   logic                  READY;
   logic [ADDR_WIDTH-1:0] MOD_ADDR;
   logic [7:0]            MOD_DATA;
   logic [7:0]            MOD;
   logic                  UPDATE;
   logic [ADDR_WIDTH-1:0] MOD_IDX;
   logic                  OVERRUN;

   modport slave (
      input  TICK, SYNC, FREQ_DIV, MOD_CYCLE, READY, MOD_DATA,
      output MOD_ADDR, MOD, UPDATE, MOD_IDX, OVERRUN
   );

   modport master (
      output TICK, SYNC, FREQ_DIV, MOD_CYCLE, READY, MOD_DATA,
      input  MOD_ADDR, MOD, UPDATE, MOD_IDX, OVERRUN
   );
endinterface

// File: rtl/mod_sampler_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider: turns the base TICK into a sample fire every FREQ_DIV+1 ticks.
//   CLK, RST  : clock, synchronous active-high reset
//   TICK      : base sampling pulse
//   SYNC      : restarts the count; a TICK in the same cycle is ignored
//   FREQ_DIV  : ticks per fire minus 1
//   FIRE      : registered one-cycle fire pulse
// -----------------------------------------------------------------------------
module tick_divider #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 TICK,
   input  logic                 SYNC,
   input  logic [DIV_WIDTH-1:0] FREQ_DIV,
   output logic                 FIRE
);

   logic [DIV_WIDTH-1:0] div_cnt_q;
   logic                 fire_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         div_cnt_q <= '0;
         fire_q    <= 1'b0;
      end else if (SYNC) begin
         div_cnt_q <= '0;
         fire_q    <= 1'b0;
      end else if (TICK) begin
         // >= also catches a FREQ_DIV lowered below the running count
         if (div_cnt_q >= FREQ_DIV) begin
            div_cnt_q <= '0;
            fire_q    <= 1'b1;
         end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
            fire_q    <= 1'b0;
         end
      end else begin
         fire_q <= 1'b0;
      end
   end

   assign FIRE = fire_q;

endmodule

// File: rtl/mod_sampler.sv
// -----------------------------------------------------------------------------
// mod_sampler: steps through the modulation sample BRAM at the divided tick
// rate and hands each sample to the modulation multiplier.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : mod_sampler_if.slave
//     TICK/SYNC/FREQ_DIV/MOD_CYCLE : timing and buffer configuration
//     MOD_ADDR/MOD_DATA            : BRAM read port
//     READY/MOD/UPDATE/MOD_IDX     : multiplier handshake and sample
//     OVERRUN                      : sticky, a fire arrived while busy
// -----------------------------------------------------------------------------
module mod_sampler
   import mod_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int BRAM_LATENCY = DEF_BRAM_LATENCY,
   parameter int DIV_WIDTH    = DEF_DIV_WIDTH
) (
   input  logic         CLK,
   input  logic         RST,
   mod_sampler_if.slave bus
);

   localparam int LAT_W = lat_cnt_width(BRAM_LATENCY);

   logic                  fire;
   state_e                state_q;
   logic [LAT_W-1:0]      lat_cnt_q;
   logic [7:0]            hold_q;
   logic [7:0]            mod_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [ADDR_WIDTH-1:0] idx_d;
   logic [ADDR_WIDTH-1:0] mod_idx_q;
   logic                  update_q;
   logic                  overrun_q;

   tick_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
      .CLK      (CLK),
      .RST      (RST),
      .TICK     (bus.TICK),
      .SYNC     (bus.SYNC),
      .FREQ_DIV (bus.FREQ_DIV),
      .FIRE     (fire)
   );

   // >= wraps immediately when MOD_CYCLE shrinks below the current index
   always_comb begin
      idx_d = (idx_q >= bus.MOD_CYCLE) ? '0 : idx_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         lat_cnt_q <= '0;
         hold_q    <= '0;
         mod_q     <= '0;
         addr_q    <= '0;
         idx_q     <= '0;
         mod_idx_q <= '0;
         update_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         update_q <= 1'b0;
         if (bus.SYNC) begin
            // abort any read in flight; MOD and OVERRUN keep their values
            idx_q   <= '0;
            state_q <= IDLE;
         end else begin
            // the index advances on every fire, dropped or not, to keep
            // the sample stream aligned with time
            if (fire) begin
               idx_q <= idx_d;
            end
            unique case (state_q)
               IDLE: begin
                  if (fire) begin
                     addr_q    <= idx_q;
                     lat_cnt_q <= '0;
                     state_q   <= READ;
                  end
               end
               READ: begin
                  if (fire) begin
                     overrun_q <= 1'b1;
                  end
                  if (lat_cnt_q == LAT_W'(BRAM_LATENCY - 1)) begin
                     hold_q  <= bus.MOD_DATA;
                     state_q <= HOLD;
                  end else begin
                     lat_cnt_q <= lat_cnt_q + 1'b1;
                  end
               end
               HOLD: begin
                  if (fire) begin
                     overrun_q <= 1'b1;
                  end
                  if (bus.READY) begin
                     mod_q     <= hold_q;
                     mod_idx_q <= addr_q;
                     update_q  <= 1'b1;
                     state_q   <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.MOD_ADDR = addr_q;
   assign bus.MOD      = mod_q;
   assign bus.UPDATE   = update_q;
   assign bus.MOD_IDX  = mod_idx_q;
   assign bus.OVERRUN  = overrun_q;

endmodule

// File: tb/tb_mod_sampler.sv
// -----------------------------------------------------------------------------
// tb_mod_sampler: directed bench for mod_sampler with a one-register BRAM
// model. Sample i of the buffer holds 10,20,30,40 for i<4 and i+100 beyond.
// -----------------------------------------------------------------------------
module tb_mod_sampler;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mod_sampler_if #(.ADDR_WIDTH(15), .DIV_WIDTH(16)) bus();

   mod_sampler #(.ADDR_WIDTH(15), .BRAM_LATENCY(2), .DIV_WIDTH(16)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   logic [7:0] mem [0:127];
   logic [7:0] bram_q;

   always @(posedge clk) bram_q <= mem[bus.MOD_ADDR[6:0]];
   assign bus.MOD_DATA = bram_q;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [7:0] exp_data(input int i);
      return (i < 4) ? 8'((i + 1) * 10) : 8'(i + 100);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sync_pulse();
      bus.SYNC = 1'b1;
      step();
      bus.SYNC = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.TICK = 1'b0; bus.SYNC = 1'b0; bus.READY = 1'b0;
      bus.FREQ_DIV = '0; bus.MOD_CYCLE = '0;
      repeat (3) step();
      n_cmp++; if (bus.MOD !== 8'd0) begin n_bad++; $display("FAIL rst_mod: got %0d want 0", bus.MOD); end
      n_cmp++; if (bus.UPDATE !== 1'b0) begin n_bad++; $display("FAIL rst_update: got %0b want 0", bus.UPDATE); end
      n_cmp++; if (bus.MOD_ADDR !== 15'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", bus.MOD_ADDR); end
      n_cmp++; if (bus.MOD_IDX !== 15'd0) begin n_bad++; $display("FAIL rst_idx: got %0d want 0", bus.MOD_IDX); end
      n_cmp++; if (bus.OVERRUN !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %0b want 0", bus.OVERRUN); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic_rate();
      int n_upd;
      logic [7:0] last_mod;
      n_upd = 0;
      bus.FREQ_DIV = 16'd3; bus.MOD_CYCLE = 15'd3; bus.READY = 1'b1;
      last_mod = 8'd0;
      for (int c = 0; c < 205; c++) begin
         bus.TICK = (c % 10 == 0);
         step();
         if (bus.UPDATE === 1'b1) begin
            n_cmp++; if (c != 34 + 40 * n_upd) begin n_bad++; $display("FAIL basic_latency: update at %0d want %0d", c, 34 + 40 * n_upd); end
            n_cmp++; if (bus.MOD !== exp_data(n_upd % 4)) begin n_bad++; $display("FAIL basic_mod: got %0d want %0d", bus.MOD, exp_data(n_upd % 4)); end
            n_cmp++; if (bus.MOD_IDX !== 15'(n_upd % 4)) begin n_bad++; $display("FAIL basic_idx: got %0d want %0d", bus.MOD_IDX, n_upd % 4); end
            n_upd++;
            last_mod = bus.MOD;
         end else begin
            n_cmp++; if (bus.MOD !== last_mod) begin n_bad++; $display("FAIL basic_mod_stable: got %0d want %0d at %0d", bus.MOD, last_mod, c); end
         end
      end
      bus.TICK = 1'b0;
      n_cmp++; if (n_upd != 5) begin n_bad++; $display("FAIL basic_count: got %0d updates want 5", n_upd); end
   endtask

   task automatic test_backpressure();
      bus.FREQ_DIV = 16'd0; bus.MOD_CYCLE = 15'd3; bus.READY = 1'b0;
      sync_pulse();
      for (int c = 0; c <= 40; c++) begin
         bus.TICK  = (c == 0 || c == 32);
         bus.READY = (c >= 30);
         step();
         n_cmp++; if (bus.UPDATE !== (c == 30 || c == 36)) begin n_bad++; $display("FAIL bp_update: got %0b at cycle %0d", bus.UPDATE, c); end
         if (c == 30) begin
            n_cmp++; if (bus.MOD !== 8'd10) begin n_bad++; $display("FAIL bp_mod0: got %0d want 10", bus.MOD); end
            n_cmp++; if (bus.MOD_IDX !== 15'd0) begin n_bad++; $display("FAIL bp_idx0: got %0d want 0", bus.MOD_IDX); end
         end
         if (c == 36) begin
            n_cmp++; if (bus.MOD !== 8'd20) begin n_bad++; $display("FAIL bp_mod1: got %0d want 20", bus.MOD); end
            n_cmp++; if (bus.MOD_IDX !== 15'd1) begin n_bad++; $display("FAIL bp_idx1: got %0d want 1", bus.MOD_IDX); end
         end
      end
      bus.TICK = 1'b0;
      n_cmp++; if (bus.OVERRUN !== 1'b0) begin n_bad++; $display("FAIL bp_overrun: got %0b want 0", bus.OVERRUN); end
   endtask

   task automatic test_overrun();
      bus.FREQ_DIV = 16'd0; bus.MOD_CYCLE = 15'd20; bus.READY = 1'b0;
      sync_pulse();
      for (int c = 0; c <= 17; c++) begin
         bus.TICK  = (c <= 3 || c == 12);
         bus.READY = (c >= 10);
         step();
         if (c == 1) begin
            n_cmp++; if (bus.OVERRUN !== 1'b0) begin n_bad++; $display("FAIL ovr_early: got %0b want 0", bus.OVERRUN); end
         end
         if (c == 2) begin
            n_cmp++; if (bus.OVERRUN !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %0b want 1", bus.OVERRUN); end
         end
         n_cmp++; if (bus.UPDATE !== (c == 10 || c == 16)) begin n_bad++; $display("FAIL ovr_update: got %0b at cycle %0d", bus.UPDATE, c); end
         if (c == 10) begin
            n_cmp++; if (bus.MOD_IDX !== 15'd0) begin n_bad++; $display("FAIL ovr_idx0: got %0d want 0", bus.MOD_IDX); end
            n_cmp++; if (bus.MOD !== 8'd10) begin n_bad++; $display("FAIL ovr_mod0: got %0d want 10", bus.MOD); end
         end
         if (c == 16) begin
            n_cmp++; if (bus.MOD_IDX !== 15'd4) begin n_bad++; $display("FAIL ovr_idx_skip: got %0d want 4", bus.MOD_IDX); end
            n_cmp++; if (bus.MOD !== 8'd104) begin n_bad++; $display("FAIL ovr_mod_skip: got %0d want 104", bus.MOD); end
         end
      end
      bus.TICK = 1'b0;
      sync_pulse();
      step();
      n_cmp++; if (bus.OVERRUN !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %0b want 1", bus.OVERRUN); end
   endtask

   task automatic test_sync();
      bus.FREQ_DIV = 16'd0; bus.MOD_CYCLE = 15'd20; bus.READY = 1'b1;
      sync_pulse();
      for (int c = 0; c <= 56; c++) begin
         bus.TICK = (c <= 42 && c % 6 == 0) || c == 44 || c == 50;
         bus.SYNC = (c == 44);
         step();
         n_cmp++; if (bus.UPDATE !== ((c <= 40 && c % 6 == 4) || c == 54)) begin n_bad++; $display("FAIL sync_update: got %0b at cycle %0d", bus.UPDATE, c); end
         if (c == 51) begin
            n_cmp++; if (bus.MOD_ADDR !== 15'd0) begin n_bad++; $display("FAIL sync_addr: got %0d want 0", bus.MOD_ADDR); end
         end
         if (c >= 45 && c <= 53) begin
            n_cmp++; if (bus.MOD !== 8'd106) begin n_bad++; $display("FAIL sync_mod_hold: got %0d want 106 at %0d", bus.MOD, c); end
         end
         if (c == 54) begin
            n_cmp++; if (bus.MOD !== 8'd10) begin n_bad++; $display("FAIL sync_mod: got %0d want 10", bus.MOD); end
            n_cmp++; if (bus.MOD_IDX !== 15'd0) begin n_bad++; $display("FAIL sync_idx: got %0d want 0", bus.MOD_IDX); end
         end
      end
      bus.TICK = 1'b0; bus.SYNC = 1'b0;
   endtask

   task automatic test_wrap_shrink();
      int n_upd;
      int exp_i;
      n_upd = 0;
      bus.FREQ_DIV = 16'd0; bus.MOD_CYCLE = 15'd99; bus.READY = 1'b1;
      sync_pulse();
      for (int c = 0; c <= 311; c++) begin
         bus.TICK = (c % 5 == 0 && c <= 305);
         if (c == 250) bus.MOD_CYCLE = 15'd9;
         step();
         if (bus.UPDATE === 1'b1) begin
            exp_i = (n_upd <= 50) ? n_upd : ((n_upd <= 60) ? n_upd - 51 : 0);
            n_cmp++; if (bus.MOD_IDX !== 15'(exp_i)) begin n_bad++; $display("FAIL wrap_idx: got %0d want %0d (update %0d)", bus.MOD_IDX, exp_i, n_upd); end
            n_cmp++; if (bus.MOD !== exp_data(exp_i)) begin n_bad++; $display("FAIL wrap_mod: got %0d want %0d (update %0d)", bus.MOD, exp_data(exp_i), n_upd); end
            n_upd++;
         end
      end
      bus.TICK = 1'b0;
      n_cmp++; if (n_upd != 62) begin n_bad++; $display("FAIL wrap_count: got %0d updates want 62", n_upd); end
   endtask

   task automatic test_reset_hold();
      bus.FREQ_DIV = 16'd0; bus.READY = 1'b0;
      for (int c = 0; c <= 20; c++) begin
         bus.TICK  = (c == 0 || c == 12);
         bus.READY = (c >= 8);
         rst       = (c == 5);
         step();
         if (c == 5) begin
            n_cmp++; if (bus.MOD !== 8'd0) begin n_bad++; $display("FAIL rh_mod: got %0d want 0", bus.MOD); end
            n_cmp++; if (bus.UPDATE !== 1'b0) begin n_bad++; $display("FAIL rh_update: got %0b want 0", bus.UPDATE); end
            n_cmp++; if (bus.MOD_ADDR !== 15'd0) begin n_bad++; $display("FAIL rh_addr: got %0d want 0", bus.MOD_ADDR); end
            n_cmp++; if (bus.MOD_IDX !== 15'd0) begin n_bad++; $display("FAIL rh_idx: got %0d want 0", bus.MOD_IDX); end
            n_cmp++; if (bus.OVERRUN !== 1'b0) begin n_bad++; $display("FAIL rh_overrun: got %0b want 0", bus.OVERRUN); end
         end
         n_cmp++; if (bus.UPDATE !== (c == 16)) begin n_bad++; $display("FAIL rh_update_seq: got %0b at cycle %0d", bus.UPDATE, c); end
         if (c == 16) begin
            n_cmp++; if (bus.MOD_IDX !== 15'd0) begin n_bad++; $display("FAIL rh_first_idx: got %0d want 0", bus.MOD_IDX); end
            n_cmp++; if (bus.MOD !== 8'd10) begin n_bad++; $display("FAIL rh_first_mod: got %0d want 10", bus.MOD); end
         end
      end
      bus.TICK = 1'b0; rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = exp_data(i);
      test_reset();
      test_basic_rate();
      test_backpressure();
      test_overrun();
      test_sync();
      test_wrap_shrink();
      test_reset_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
